// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and
// default operand width.
package seq_divider32_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider32_div_step.sv
// One restoring shift-and-subtract iteration: trial-subtract the divisor from
// the partial remainder extended by the next dividend bit.
import seq_divider32_pkg::*;

module div_step #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] a_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  always_comb begin
    trial  = {r, a[WIDTH-1]} - {1'b0, b};
    // A clear sign bit means the divisor fit; otherwise restore by shifting.
    q_bit  = ~trial[WIDTH];
    r_next = q_bit ? trial[WIDTH-1:0] : {r[WIDTH-2:0], a[WIDTH-1]};
    a_next = {a[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring integer divider, one quotient bit per clock, with
// signed/unsigned operands and a divide-by-zero short path.
import seq_divider32_pkg::*;

module seq_divider32 #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    count_q;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] a_step;
  logic             q_bit_step;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quot_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .a      (a_q),
    .b      (b_q),
    .r_next (r_step),
    .a_next (a_step),
    .q_bit  (q_bit_step)
  );

  always_comb begin
    dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    quot_mag     = {a_q[WIDTH-2:0], q_bit_step};
  end

  // NOTE: every register here, working datapath included, is cleared by the
  // async reset so an aborted divide leaves no stale operands behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= DIV_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      done <= 1'b0;
      unique case (state)
        DIV_IDLE, DIV_DONE: begin
          if (start && (divisor == '0)) begin
            state       <= DIV_DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else if (start) begin
            state   <= DIV_RUN;
            busy    <= 1'b1;
            a_q     <= dividend_mag;
            b_q     <= divisor_mag;
            r_q     <= '0;
            count_q <= '0;
            neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= is_signed & dividend[WIDTH-1];
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_RUN: begin
          a_q     <= a_step;
          r_q     <= r_step;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state       <= DIV_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= neg_q ? -quot_mag : quot_mag;
            remainder   <= neg_r ? -r_step : r_step;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: a driver pushes arithmetic-model results,
// a monitor pops and compares them whenever done pulses.
module tb_seq_divider32;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_cyc;
    int           busy_cycles;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  bit   flush = 1'b0;
  exp_t sb[$];

  seq_divider32 #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer division; SV '/' and '%' truncate toward zero and
  // give the remainder the dividend's sign, which is the required behaviour.
  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                 input logic sg, input int accept_cyc);
    exp_t   e;
    longint sd, sv;
    if (dvs == '0) begin
      e.q = '1;
      e.r = dvd;
      e.dbz = 1'b1;
      e.done_cyc = accept_cyc;
      e.busy_cycles = 0;
    end else begin
      if (sg) begin
        sd = longint'(signed'(dvd));
        sv = longint'(signed'(dvs));
      end else begin
        sd = longint'({32'b0, dvd});
        sv = longint'({32'b0, dvs});
      end
      e.q = W'(sd / sv);
      e.r = W'(sd % sv);
      e.dbz = 1'b0;
      e.done_cyc = accept_cyc + W;
      e.busy_cycles = W;
    end
    return e;
  endfunction

  // Called at a negedge while the DUT is in IDLE or DONE.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sg);
    dividend  = dvd;
    divisor   = dvs;
    is_signed = sg;
    start     = 1'b1;
    sb.push_back(model(dvd, dvs, sg, cyc + 1));
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("timeout_waiting_done", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Waits for the done cycle of the outstanding divide, then issues in it.
  task automatic issue_b2b(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sg);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("timeout_b2b_done", 64'(seen), 64'd1);
    else issue(dvd, dvs, sg);
  endtask

  function automatic logic [W-1:0] rand_divisor(input logic sg);
    int unsigned k = $urandom_range(0, 9);
    logic [W-1:0] d;
    if (k == 0) d = '0;
    else if (k <= 3) begin
      d = W'($urandom_range(1, 15));
      if (sg && $urandom_range(0, 1) == 1) d = -d;
    end else if (k == 4) d = '1;
    else begin
      d = $urandom >> $urandom_range(0, 31);
      if (d == '0) d = 1;
    end
    return d;
  endfunction

  // Monitor: compares every done pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!flush) begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
          end else begin
            e = sb.pop_front();
            check("quotient", 64'(quotient), 64'(e.q));
            check("remainder", 64'(remainder), 64'(e.r));
            check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            check("busy_cycles", 64'(busy_cnt), 64'(e.busy_cycles));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d1, d2;
    logic         s1, s2;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_remainder", 64'(remainder), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    @(negedge clk); issue(32'd100, 32'd7, 1'b0); wait_idle();
    @(negedge clk); issue(-32'sd100, 32'd7, 1'b1); wait_idle();
    @(negedge clk); issue(32'd100, -32'sd7, 1'b1); wait_idle();
    @(negedge clk); issue(32'd5, 32'd0, 1'b0); wait_idle();
    @(negedge clk); issue(32'd5, 32'd0, 1'b1); wait_idle();
    @(negedge clk); issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    @(negedge clk); issue(32'hFFFF_FFFF, 32'd1, 1'b0); wait_idle();

    // Start mid-RUN with new operands must be ignored.
    @(negedge clk); issue(32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    dividend = 32'd9; divisor = 32'd0; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Back-to-back: second start issued in the first DONE cycle.
    @(negedge clk); issue(32'd12345, 32'd17, 1'b0);
    issue_b2b(-32'sd999, 32'd10, 1'b1);
    wait_idle();

    // Reset mid-RUN aborts and clears outputs asynchronously.
    @(negedge clk); issue(32'd77, 32'd5, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    flush = 1'b1;
    reset = 1'b0;
    #1;
    sb.delete();
    busy_cnt = 0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    @(negedge clk); issue(32'd9, 32'd3, 1'b0); wait_idle();

    // Randomized pairs, the second of each issued back-to-back.
    for (int i = 0; i < 24; i++) begin
      s1 = 1'($urandom); d1 = rand_divisor(s1);
      s2 = 1'($urandom); d2 = rand_divisor(s2);
      @(negedge clk); issue($urandom, d1, s1);
      if (i % 2 == 0) issue_b2b($urandom >> $urandom_range(0, 31), d2, s2);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
